forward_hazard_unit: RTL and testbench
======================================

// Module: forward_hazard_unit
// PURPOSE
//  Parametrised forwarding and load-use hazard unit for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  - Pre-decodes the EX operand mux selects one cycle early, from the ID-stage sources, and registers them.
//  - Detects load-use hazards and raises stall/flush to insert one bubble.
//  - Freezes all of its state while data memory holds the pipeline.
// PARAMETERS
//  REG_AW        5  register address width (number of regs = 2**REG_AW)
//  R0_HARDWIRED  1  1: address 0 is constant zero, never forwarded or stalled on; 0: ordinary register
// PORTS
//  clk          in   1       pipeline clock; all state updates on posedge
//  reset        in   1       asynchronous, active-high reset
//  id_rs        in   REG_AW  IF/ID.Rs of the instruction now in ID
//  id_rt        in   REG_AW  IF/ID.Rt
//  id_uses_rs   in   1       ID instruction reads Rs
//  id_uses_rt   in   1       ID instruction reads Rt
//  ex_dest      in   REG_AW  ID/EX destination register
//  ex_regwrite  in   1       ID/EX RegWrite
//  ex_memread   in   1       ID/EX MemRead (instruction in EX is a load)
//  mem_dest     in   REG_AW  EX/MEM destination register
//  mem_regwrite in   1       EX/MEM RegWrite
//  mem_stall    in   1       data memory not ready; whole pipeline frozen this cycle
//  forward_a    out  2       EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB (registered)
//  forward_b    out  2       EX operand B select, same encoding (registered)
//  stall        out  1       hold PC and IF/ID (combinational)
//  flush_ex     out  1       load bubble into ID/EX; equals stall
// BEHAVIOUR
//  - Reset (async): forward_a = forward_b = 2'b00, state = RUN. stall and flush_ex are forced 0 while reset is high.
//  - match(s, d, w) = w & (d == s) & !(R0_HARDWIRED & d == 0).
//  - load_use = ex_regwrite & ex_memread & ((id_uses_rs & match(id_rs, ex_dest, 1)) | (id_uses_rt & match(id_rt, ex_dest, 1))).
//  - stall = flush_ex = load_use & !mem_stall & (state == RUN). Same-cycle, no latency.
//  - Select precompute for operand A (B is identical with id_rt):
//    - 2'b10 if match(id_rs, ex_dest, ex_regwrite), i.e. that producer will be in MEM next cycle.
//    - else 2'b01 if match(id_rs, mem_dest, mem_regwrite), i.e. will be in WB.
//    - else 2'b00. The EX/MEM match has priority over MEM/WB (youngest producer wins).
//  - Register update at posedge, one-cycle latency:
//    - mem_stall = 1: forward_a/forward_b hold.
//    - else stall = 1: both load 2'b00 (bubble enters EX).
//    - else: both load the precomputed selects.
//  - Post-stall case: next cycle the load is in MEM and the bubble is in EX, so the precompute yields 01.
//    The dependent instruction then reads the load data from MEM/WB in EX. No second stall.
//  - Unused source (id_uses_* = 0) may still produce a nonzero select. Harmless; the operand is ignored.
//  - The register file must be write-before-read. WB-to-ID same-cycle is not forwarded here.
//  - FSM states:
//    - RUN: normal operation. Goes to HOLD when mem_stall = 1.
//    - HOLD: outputs frozen and stall forced 0, since the memory freeze already covers IF/ID.
//      Returns to RUN on the first cycle with mem_stall = 0.
//    - Load-use is re-evaluated in that RUN cycle.
//  - Reset mid-stall or mid-HOLD: immediate return to RUN with all outputs at reset values.
// CONFIGURATION
//  FWD_STATS_EN defined: adds outputs fwd_count[31:0] and stall_count[31:0].
//    - Both reset to 0 and wrap modulo 2**32.
//    - fwd_count increments by 1 per non-held posedge where either registered select loads nonzero.
//    - stall_count increments by 1 per cycle with stall = 1.
//  FWD_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  - Reset asserted mid-cycle with forward_a = 10 -> forward_a/forward_b = 00 and stall = 0 immediately, before any clk edge.
//  - id_rs = 3, id_uses_rs = 1; ex_dest = 3, ex_regwrite = 1, ex_memread = 0 -> after one edge forward_a = 10, forward_b = 00, stall = 0.
//  - id_rt = 7; ex_dest = 7 and mem_dest = 7, both writing -> forward_b = 10 (EX/MEM priority).
//    Then ex_regwrite = 0 -> next edge forward_b = 01.
//  - Load to r5 in EX (ex_memread = 1), id_rs = 5 -> stall = flush_ex = 1 that cycle and forward_a loads 00.
//    Next cycle, bubble in EX and mem_dest = 5 -> stall = 0 and forward_a loads 01.
//  - R0_HARDWIRED = 1 with id_rs = 0, ex_dest = 0, writing load -> no stall, forward_a = 00.
//    Repeat with R0_HARDWIRED = 0 -> stall = 1.
//  - mem_stall = 1 for 3 cycles during a load-use match -> stall = 0 and forward_* held throughout.
//    mem_stall falls -> stall = 1 in that cycle. With FWD_STATS_EN, stall_count increments by exactly 1.

Source files
------------

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM register fields in, EX mux selects and stall out.
// FWD_STATS_EN adds the fwd_count / stall_count statistics outputs.
interface forward_hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_regwrite;
    logic              mem_stall;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              stall;
    logic              flush_ex;
`ifdef FWD_STATS_EN
    logic [31:0]       fwd_count;
    logic [31:0]       stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dest, ex_regwrite, ex_memread,
               mem_dest, mem_regwrite, mem_stall,
        input  forward_a, forward_b, stall, flush_ex, fwd_count, stall_count
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dest, ex_regwrite, ex_memread,
               mem_dest, mem_regwrite, mem_stall,
        output forward_a, forward_b, stall, flush_ex, fwd_count, stall_count
    );
`else
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dest, ex_regwrite, ex_memread,
               mem_dest, mem_regwrite, mem_stall,
        input  forward_a, forward_b, stall, flush_ex
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_dest, ex_regwrite, ex_memread,
               mem_dest, mem_regwrite, mem_stall,
        output forward_a, forward_b, stall, flush_ex
    );
`endif
endinterface

// File: rtl/forward_hazard_unit.sv
// Forwarding-select precompute and load-use hazard detection for the 5-stage pipeline.
// Optional FWD_STATS_EN macro adds forward/stall event counters.
module forward_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    forward_hazard_unit_if.slave  bus
);
    function automatic logic match(input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] d,
                                   input logic w);
        return w && (d == s) && !(R0_HARDWIRED && (d == '0));
    endfunction

    logic       load_use;
    logic       stall_int;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;

    // Selects are resolved for the instruction now in ID: the EX producer will sit in
    // EX/MEM next cycle, the MEM producer in MEM/WB. Youngest producer wins.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (match(bus.id_rs, bus.ex_dest, bus.ex_regwrite))        sel_a = 2'b10;
        else if (match(bus.id_rs, bus.mem_dest, bus.mem_regwrite)) sel_a = 2'b01;
        if (match(bus.id_rt, bus.ex_dest, bus.ex_regwrite))        sel_b = 2'b10;
        else if (match(bus.id_rt, bus.mem_dest, bus.mem_regwrite)) sel_b = 2'b01;
    end

    assign load_use = bus.ex_regwrite && bus.ex_memread &&
                      ((bus.id_uses_rs && match(bus.id_rs, bus.ex_dest, 1'b1)) ||
                       (bus.id_uses_rt && match(bus.id_rt, bus.ex_dest, 1'b1)));

    // The HOLD state is exactly the set of cycles with mem_stall high and is left in the
    // same cycle mem_stall drops, so gating on mem_stall is the whole RUN/HOLD machine.
    assign stall_int    = load_use && !bus.mem_stall && !reset;
    assign bus.stall    = stall_int;
    assign bus.flush_ex = stall_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (!bus.mem_stall) begin
            if (stall_int) begin
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end else begin
                fwd_a_q <= sel_a;
                fwd_b_q <= sel_b;
            end
        end
    end

    assign bus.forward_a = fwd_a_q;
    assign bus.forward_b = fwd_b_q;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (stall_int) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!bus.mem_stall && !stall_int && ((sel_a != 2'b00) || (sel_b != 2'b00)))
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign bus.fwd_count   = fwd_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench: two DUTs (R0 hardwired / ordinary) driven by directed then random
// pipeline traffic, checked against a rule-level model of forwarding and load-use.
`timescale 1ns/1ps
module tb_forward_hazard_unit;
    typedef struct {
        logic [4:0] rs, rt, exd, memd;
        bit urs, urt, exw, exm, memw, mst, rst;
    } stim_t;

    typedef struct {
        logic [1:0]  fa [2];
        logic [1:0]  fb [2];
        logic        st [2];
        logic [31:0] fc [2];
        logic [31:0] sc [2];
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    forward_hazard_unit_if #(.REG_AW(5)) if0 ();
    forward_hazard_unit_if #(.REG_AW(5)) if1 ();

    forward_hazard_unit #(.REG_AW(5), .R0_HARDWIRED(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    forward_hazard_unit #(.REG_AW(5), .R0_HARDWIRED(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input int rs, input bit urs, input int rt, input bit urt,
                                 input int exd, input bit exw, input bit exm,
                                 input int memd, input bit memw, input bit mst, input bit rst);
        stim_t s;
        s.rs = 5'(rs);  s.urs = urs;  s.rt = 5'(rt);  s.urt = urt;
        s.exd = 5'(exd); s.exw = exw; s.exm = exm;
        s.memd = 5'(memd); s.memw = memw; s.mst = mst; s.rst = rst;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        if0.id_rs = s.rs;   if0.id_rt = s.rt;   if0.id_uses_rs = s.urs; if0.id_uses_rt = s.urt;
        if0.ex_dest = s.exd; if0.ex_regwrite = s.exw; if0.ex_memread = s.exm;
        if0.mem_dest = s.memd; if0.mem_regwrite = s.memw; if0.mem_stall = s.mst;
        if1.id_rs = s.rs;   if1.id_rt = s.rt;   if1.id_uses_rs = s.urs; if1.id_uses_rt = s.urt;
        if1.ex_dest = s.exd; if1.ex_regwrite = s.exw; if1.ex_memread = s.exm;
        if1.mem_dest = s.memd; if1.mem_regwrite = s.memw; if1.mem_stall = s.mst;
    endtask

    // Reference model: a register counts as "written by a producer" unless it is a hardwired r0.
    function automatic bit writes(input logic [4:0] dst, input bit wr, input bit r0h);
        return wr && !(r0h && dst == 5'd0);
    endfunction

    function automatic bit m_stall(input stim_t s, input bit r0h);
        bit reads_load;
        if (s.mst || !(s.exw && s.exm) || !writes(s.exd, 1'b1, r0h)) return 1'b0;
        reads_load = (s.urs && s.rs == s.exd) || (s.urt && s.rt == s.exd);
        return reads_load;
    endfunction

    function automatic logic [1:0] m_sel(input stim_t s, input bit r0h, input logic [4:0] src);
        // producers listed youngest first: {dest, writes, mux code}
        logic [4:0] dst [2];
        bit         wr  [2];
        logic [1:0] code [2];
        dst[0] = s.exd;  wr[0] = s.exw;  code[0] = 2'b10;
        dst[1] = s.memd; wr[1] = s.memw; code[1] = 2'b01;
        for (int p = 0; p < 2; p++)
            if (writes(dst[p], wr[p], r0h) && dst[p] == src) return code[p];
        return 2'b00;
    endfunction

    task automatic check_dut(input int k, input logic [1:0] fa, input logic [1:0] fb,
                             input logic st, input logic fl, input exp_t e);
        string tag;
        tag = (k == 0) ? "r0hw" : "r0reg";
        chk({tag, " forward_a"}, 32'(fa), 32'(e.fa[k]));
        chk({tag, " forward_b"}, 32'(fb), 32'(e.fb[k]));
        chk({tag, " stall"},     32'(st), 32'(e.st[k]));
        chk({tag, " flush_ex"},  32'(fl), 32'(e.st[k]));
    endtask

    // Monitor: every negedge where an expectation is pending, compare both DUTs.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_dut(0, if0.forward_a, if0.forward_b, if0.stall, if0.flush_ex, e);
            check_dut(1, if1.forward_a, if1.forward_b, if1.stall, if1.flush_ex, e);
`ifdef FWD_STATS_EN
            chk("r0hw fwd_count",    if0.fwd_count,   e.fc[0]);
            chk("r0hw stall_count",  if0.stall_count, e.sc[0]);
            chk("r0reg fwd_count",   if1.fwd_count,   e.fc[1]);
            chk("r0reg stall_count", if1.stall_count, e.sc[1]);
`endif
        end
    end

    initial begin
        stim_t       tab [$];
        stim_t       prev, cur;
        logic [1:0]  fa [2];
        logic [1:0]  fb [2];
        logic [31:0] fc [2];
        logic [31:0] sc [2];
        bit          r0h [2];
        exp_t        e;

        r0h[0] = 1'b1; r0h[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin fa[k] = 0; fb[k] = 0; fc[k] = 0; sc[k] = 0; end

        tab.push_back(mk(3,1, 0,0, 3,1,0, 0,0, 0,0)); // EX producer -> forward_a 10
        tab.push_back(mk(3,1, 0,0, 3,1,1, 0,0, 0,1)); // load-use, then reset mid-cycle
        tab.push_back(mk(0,0, 7,1, 7,1,0, 7,1, 0,0)); // both producers -> EX/MEM wins
        tab.push_back(mk(0,0, 7,1, 7,0,0, 7,1, 0,0)); // only MEM producer -> 01
        tab.push_back(mk(5,1, 0,0, 5,1,1, 0,0, 0,0)); // load-use on r5 -> stall
        tab.push_back(mk(5,1, 0,0, 0,0,0, 5,1, 0,0)); // bubble in EX, load in MEM -> 01
        tab.push_back(mk(0,1, 0,0, 0,1,1, 0,0, 0,0)); // r0 load: stalls only when not hardwired
        tab.push_back(mk(4,1, 0,0, 4,1,1, 0,0, 1,0)); // memory freeze over a load-use
        tab.push_back(mk(4,1, 0,0, 4,1,1, 0,0, 1,0));
        tab.push_back(mk(4,1, 0,0, 4,1,1, 0,0, 1,0));
        tab.push_back(mk(4,1, 0,0, 4,1,1, 0,0, 0,0)); // freeze released -> stall once
        tab.push_back(mk(4,1, 0,0, 0,0,0, 4,1, 0,0));

        reset = 1'b1;
        prev  = mk(0,0, 0,0, 0,0,0, 0,0, 0,1);
        apply(prev);
        #3;
        chk("reset forward_a", 32'(if0.forward_a), 32'd0);
        chk("reset forward_b", 32'(if1.forward_b), 32'd0);
        chk("reset stall",     32'(if0.stall),     32'd0);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (prev.rst) begin
                    fa[k] = 0; fb[k] = 0; fc[k] = 0; sc[k] = 0;
                end else if (!prev.mst) begin
                    if (m_stall(prev, r0h[k])) begin
                        fa[k] = 0; fb[k] = 0; sc[k]++;
                    end else begin
                        fa[k] = m_sel(prev, r0h[k], prev.rs);
                        fb[k] = m_sel(prev, r0h[k], prev.rt);
                        if (fa[k] != 0 || fb[k] != 0) fc[k]++;
                    end
                end
            end
            reset = 1'b0;

            if (i < tab.size()) cur = tab[i];
            else cur = mk($urandom_range(0,3), 1'($urandom_range(0,1)),
                          $urandom_range(0,3), 1'($urandom_range(0,1)),
                          $urandom_range(0,3), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                          $urandom_range(0,3), 1'($urandom_range(0,1)),
                          ($urandom_range(0,3) == 0), ($urandom_range(0,59) == 0));
            apply(cur);

            if (cur.rst) begin
                #1;
                chk("pre-reset forward_a", 32'(if0.forward_a), 32'(fa[0]));
                chk("pre-reset stall",     32'(if1.stall),     32'(m_stall(cur, 1'b0)));
                reset = 1'b1;
                #1;
                chk("async reset forward_a", 32'(if0.forward_a), 32'd0);
                chk("async reset forward_b", 32'(if1.forward_b), 32'd0);
                chk("async reset stall",     32'(if1.stall),     32'd0);
                chk("async reset flush_ex",  32'(if0.flush_ex),  32'd0);
                for (int k = 0; k < 2; k++) begin fa[k] = 0; fb[k] = 0; fc[k] = 0; sc[k] = 0; end
            end

            for (int k = 0; k < 2; k++) begin
                e.fa[k] = fa[k];
                e.fb[k] = fb[k];
                e.st[k] = cur.rst ? 1'b0 : m_stall(cur, r0h[k]);
                e.fc[k] = fc[k];
                e.sc[k] = sc[k];
            end
            sb.push_back(e);
            prev = cur;
        end

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
